// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key_debounce front-panel conditioner.
package key_pkg;

  typedef enum logic [1:0] {IDLE, HELD, GAP} state_t;

  localparam logic [7:0] KEY_NONE = 8'hFF;

  function automatic logic single_low(input logic [7:0] v);
    logic [3:0] zeros;
    zeros = '0;
    for (int i = 0; i < 8; i++) zeros = zeros + {3'b000, ~v[i]};
    return zeros == 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw active-low levels in, cleaned key vector and press strobe out.
interface key_debounce_if;
  logic [7:0] raw_key;
  logic [7:0] key;
  logic       press;

  modport master (output raw_key, input key, input press);
  modport slave  (input raw_key, output key, output press);
endinterface

// File: rtl/key_debounce_filter.sv
// Two-flop synchroniser, chord rejection and stability counter producing the debounced vector.
module key_filter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] raw_key,
  output logic [7:0] deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync1, sync2, cand, filt;
  logic [CW-1:0] cnt;

  // Multi-key chords look like a release so they can never reach the setter.
  assign filt = (sync2 == KEY_NONE || single_low(sync2)) ? sync2 : KEY_NONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= KEY_NONE;
      sync2 <= KEY_NONE;
      cand  <= KEY_NONE;
      deb   <= KEY_NONE;
      cnt   <= '0;
    end else begin
      sync1 <= raw_key;
      sync2 <= sync1;
      cand  <= filt;
      if (filt != cand)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      if (filt == cand && cnt == CNT_HIT)
        deb <= cand;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Key debounce top: filter plus IDLE/HELD/GAP sequencer that inserts auto-repeat gaps.
module key_debounce
  import key_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter logic [7:0] REPEAT_MASK     = 8'b11000000
) (
  input logic         clock,
  input logic         reset,
  key_debounce_if.slave bus
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] T_SAT      = TW'(TMAX - 1);
  localparam logic [TW-1:0] DELAY_HIT  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_HIT = TW'(REPEAT_PERIOD - 1);

  logic [7:0]    deb;
  state_t        state, state_n;
  logic [7:0]    lat, lat_n, key_q, key_n;
  logic          press_q, press_n, first, first_n;
  logic [TW-1:0] timer, timer_n;
  logic          repeat_key;

  key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
    .clock   (clock),
    .reset   (reset),
    .raw_key (bus.raw_key),
    .deb     (deb)
  );

  assign repeat_key = |(~lat & REPEAT_MASK);
  assign bus.key    = key_q;
  assign bus.press  = press_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      lat     <= KEY_NONE;
      key_q   <= KEY_NONE;
      press_q <= 1'b0;
      timer   <= '0;
      first   <= 1'b1;
    end else begin
      state   <= state_n;
      lat     <= lat_n;
      key_q   <= key_n;
      press_q <= press_n;
      timer   <= timer_n;
      first   <= first_n;
    end
  end

  always_comb begin
    state_n = state;
    lat_n   = lat;
    key_n   = key_q;
    press_n = 1'b0;
    timer_n = timer;
    first_n = first;
    case (state)
      IDLE: begin
        key_n = KEY_NONE;
        if (deb != KEY_NONE) begin
          lat_n   = deb;
          key_n   = deb;
          press_n = 1'b1;
          timer_n = '0;
          first_n = 1'b1;
          state_n = HELD;
        end
      end
      HELD: begin
        key_n   = lat;
        timer_n = (timer == T_SAT) ? timer : timer + TW'(1);
        // Release is tested first so it wins over a coincident repeat gap.
        if (deb != lat) begin
          key_n   = KEY_NONE;
          state_n = IDLE;
        end else if (repeat_key && timer == (first ? DELAY_HIT : PERIOD_HIT)) begin
          key_n   = KEY_NONE;
          state_n = GAP;
        end
      end
      GAP: begin
        if (deb == lat) begin
          key_n   = lat;
          press_n = 1'b1;
          timer_n = '0;
          first_n = 1'b0;
          state_n = HELD;
        end else begin
          key_n   = KEY_NONE;
          state_n = IDLE;
        end
      end
      default: begin
        key_n   = KEY_NONE;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat timings.
module tb_key_debounce;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  key_debounce_if bus();

  key_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (8'b11000000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // One stretch of constant raw_key: key shows key_old until edge change_at
  // (0 = never), then key_new; press pulses at change_at when press_on.
  typedef struct {
    string      name;
    logic [7:0] raw;
    int         cycles;
    logic [7:0] key_old;
    logic [7:0] key_new;
    int         change_at;
    logic       press_on;
  } seg_t;

  seg_t segs[$];

  function automatic seg_t mk(input string name, input logic [7:0] raw, input int cycles,
                              input logic [7:0] key_old, input logic [7:0] key_new,
                              input int change_at, input logic press_on);
    seg_t s;
    s.name = name; s.raw = raw; s.cycles = cycles; s.key_old = key_old;
    s.key_new = key_new; s.change_at = change_at; s.press_on = press_on;
    return s;
  endfunction

  task automatic cyc(input logic [7:0] raw, input logic rst, input logic [7:0] ek,
                     input logic ep, input string name, input int e);
    bus.raw_key = raw;
    reset = rst;
    @(posedge clock);
    #1;
    checks++;
    if (bus.key !== ek) begin
      failures++;
      $display("FAIL %s edge %0d key: got %h required %h", name, e, bus.key, ek);
    end
    checks++;
    if (bus.press !== ep) begin
      failures++;
      $display("FAIL %s edge %0d press: got %b required %b", name, e, bus.press, ep);
    end
  endtask

  task automatic run_seg(input seg_t s);
    logic [7:0] ek;
    logic       ep;
    for (int e = 1; e <= s.cycles; e++) begin
      ek = (s.change_at != 0 && e >= s.change_at) ? s.key_new : s.key_old;
      ep = (s.change_at != 0 && e == s.change_at) ? s.press_on : 1'b0;
      cyc(s.raw, 1'b0, ek, ep, s.name, e);
    end
  endtask

  // Repeat key BF held from edge 1: low for RD cycles, FF gap, then RP low / 1 FF.
  function automatic logic [7:0] rep_key(input int e);
    int t;
    if (e < DC + 4) return 8'hFF;
    t = e - (DC + 4);
    if (t < RD) return 8'hBF;
    t = t - RD;
    if (t == 0) return 8'hFF;
    t = t - 1;
    return ((t % (RP + 1)) < RP) ? 8'hBF : 8'hFF;
  endfunction

  function automatic logic rep_press(input int e);
    int first_rep;
    first_rep = DC + 4 + RD + 1;
    if (e == DC + 4) return 1'b1;
    if (e >= first_rep && ((e - first_rep) % (RP + 1)) == 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    bus.raw_key = 8'hFF;

    for (int i = 1; i <= 3; i++) cyc(8'hFF, 1'b1, 8'hFF, 1'b0, "reset", i);

    segs.push_back(mk("idle",          8'hFF, 10, 8'hFF, 8'hFF, 0, 1'b0));
    segs.push_back(mk("clean_press",   8'hFE, 30, 8'hFF, 8'hFE, 8, 1'b1));
    segs.push_back(mk("clean_release", 8'hFF, 12, 8'hFE, 8'hFF, 8, 1'b0));
    segs.push_back(mk("chord",         8'hFC, 50, 8'hFF, 8'hFF, 0, 1'b0));
    segs.push_back(mk("chord_off",     8'hFF, 10, 8'hFF, 8'hFF, 0, 1'b0));
    segs.push_back(mk("norep_hold",    8'hFE, 40, 8'hFF, 8'hFE, 8, 1'b1));
    segs.push_back(mk("norep_release", 8'hFF, 12, 8'hFE, 8'hFF, 8, 1'b0));
    foreach (segs[i]) run_seg(segs[i]);

    // Bounce: toggling every 2 cycles never survives the stability count.
    for (int i = 0; i < 20; i++)
      cyc(((i / 2) % 2 == 0) ? 8'hFE : 8'hFF, 1'b0, 8'hFF, 1'b0, "bounce", i + 1);
    run_seg(mk("bounce_settle",  8'hFE, 14, 8'hFF, 8'hFE, 8, 1'b1));
    run_seg(mk("bounce_release", 8'hFF, 12, 8'hFE, 8'hFF, 8, 1'b0));

    // Slide FE -> FD: one FF cycle at edge 8, FD with a fresh press at edge 9.
    run_seg(mk("slide_fe", 8'hFE, 20, 8'hFF, 8'hFE, 8, 1'b1));
    for (int e = 1; e <= 20; e++)
      cyc(8'hFD, 1'b0, (e < 8) ? 8'hFE : (e == 8) ? 8'hFF : 8'hFD, (e == 9), "slide_fd", e);
    run_seg(mk("slide_release", 8'hFF, 12, 8'hFD, 8'hFF, 8, 1'b0));

    // Auto-repeat on BF, released after 40 cycles; release lands on a repeat boundary.
    for (int e = 1; e <= 60; e++)
      cyc((e <= 40) ? 8'hBF : 8'hFF, 1'b0,
          (e < 48) ? rep_key(e) : 8'hFF,
          (e < 48) ? rep_press(e) : 1'b0, "repeat", e);

    // Reset mid-hold, then the held button needs the full latency again.
    run_seg(mk("rst_hold", 8'hBF, 12, 8'hFF, 8'hBF, 8, 1'b1));
    cyc(8'hBF, 1'b1, 8'hFF, 1'b0, "rst_pulse", 1);
    run_seg(mk("rst_rehold",  8'hBF, 9,  8'hFF, 8'hBF, 8, 1'b1));
    run_seg(mk("rst_release", 8'hFF, 12, 8'hBF, 8'hFF, 8, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner between the eight raw active-low front-panel buttons and the destination-temperature setter. Synchronises and debounces the buttons and rejects multi-key chords. Presents a clean active-low `key` vector with exactly zero or one bit low, plus a one-cycle `press` strobe. Generates auto-repeat on the step keys by inserting one-cycle all-released gaps, so the release-gated step logic downstream sees a fresh press per repeat.

## Interface
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles before a new pattern is accepted (≥1)
- `REPEAT_DELAY`, 25000000, HELD cycles before the first repeat gap (≥2)
- `REPEAT_PERIOD`, 5000000, HELD cycles between subsequent repeat gaps (≥2)
- `REPEAT_MASK`, 8'b11000000, bit set = that key auto-repeats
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `raw_key`  in  8  asynchronous button levels, active-low
- `key`  out  8  registered cleaned vector; 8'hFF = none, else exactly one bit low
- `press`  out  1  one-cycle pulse on the first cycle `key` shows a key (initial press or repeat)

## Operation
- Sync: two flops (`sync1`, `sync2`) on `raw_key`.
- Filter: `filt` = `sync2` if all-high or exactly one bit low; otherwise 8'hFF. Chords read as released.
- Debounce:
  - `cand` <= `filt` every cycle.
  - `cnt` clears when `filt` != `cand`; otherwise increments, saturating at `DEBOUNCE_CYCLES`.
  - `deb` <= `cand` when `filt` == `cand` and `cnt` == `DEBOUNCE_CYCLES`-1.
- FSM (states IDLE, HELD, GAP; `lat` = latched key; `first` = delay/period select):
  - IDLE: `key`=FF. If `deb`!=FF: `lat`<=`deb`, `key`<=`deb`, `press`<=1, `timer`<=0, `first`<=1, go HELD.
  - HELD: `key`=`lat`, `timer`++.
    - `deb`!=`lat` (release or different key): go IDLE, `key`<=FF. Release wins over repeat in the same cycle.
    - Else if `lat` is in `REPEAT_MASK` and `timer` == limit−1 (limit = `first` ? `REPEAT_DELAY` : `REPEAT_PERIOD`): go GAP, `key`<=FF.
  - GAP: one cycle only.
    - `deb`==`lat`: go HELD, `key`<=`lat`, `press`<=1, `timer`<=0, `first`<=0.
    - Otherwise: go IDLE.
- Direct key-to-key change always passes through IDLE, giving at least one FF cycle between distinct keys.
- Non-repeat keys stay in HELD indefinitely with no gaps. `timer` saturates and does not wrap.
- Widths: `cnt` is clog2(`DEBOUNCE_CYCLES`+1) bits. `timer` is clog2(max(`REPEAT_DELAY`, `REPEAT_PERIOD`)) bits.

## Timing
- Reset values: `sync1`, `sync2`, `cand`, `deb`, `lat`, `key` = 8'hFF; `cnt`, `timer` = 0; `press` = 0; `first` = 1; state IDLE. Reset overrides everything in its cycle.
- Press latency: edge 1 is the first edge sampling the new `raw_key`.
  - `deb` updates at edge `DEBOUNCE_CYCLES`+3.
  - `key` and `press` update at edge `DEBOUNCE_CYCLES`+4.
- Release latency is identical: `key` reads FF at edge `DEBOUNCE_CYCLES`+4.
- Any `filt` change restarts the debounce count, so bounces shorter than `DEBOUNCE_CYCLES` never reach `key`.
- Repeat key held continuously: `key` is low for `REPEAT_DELAY` cycles, FF for 1, then alternates `REPEAT_PERIOD` low / 1 FF.
- Reset mid-hold: `key`=FF from the edge after `reset` is sampled high. After deassert, a held button needs the full press latency again.
- `press` never asserts in two consecutive cycles.

## Structure
- Shared package `key_pkg` holds:
  - the state enum {IDLE, HELD, GAP};
  - `KEY_NONE` = 8'hFF;
  - function `single_low(v)` returning 1 for exactly one zero bit.
- Sub-module `key_filter` covers sync, chord filter and debounce, outputting `deb`. The FSM and repeat timer live in the top.

## Test plan
Bench overrides: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- Clean press: `raw_key`=FE held 30 cycles, then FF → `key`=FE and `press`=1 at edge 8; `press` then 0; `key`=FF 8 edges after release.
- Bounce: `raw_key` toggles FE/FF every 2 cycles for 20 cycles, then holds FE → `key` stays FF throughout; FE appears 8 edges after the last transition.
- Chord: `raw_key`=FC for 50 cycles → `key`=FF, `press`=0 throughout.
- Repeat: `raw_key`=BF held 40 cycles → BF×10, FF×1, BF×5, FF×1, …; `press` at each BF onset. FE held 40 cycles → no gaps, single `press`.
- Slide: FE held 20 cycles, then FD directly → `key` FE → ≥1 FF cycle → FD; two `press` pulses.
- Reset mid-hold: BF held, `reset` pulsed 1 cycle → `key`=FF, `press`=0 next edge; BF returns 8 edges after deassert, with `press`.
